// File: rtl/vector_decode_stage_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vector_decode_stage_if                                           |
// | Fetch, write-back and ID/EX bundle of the vector ASIP ID stage.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface vector_decode_stage_if #(
  parameter int REG_W    = 8,
  parameter int SEL_BITS = 2,
  parameter int VEC_LEN  = 4
);
  logic [15:0]              instr;
  logic                     in_valid;
  logic                     in_ready;
  logic                     ex_stall;
  logic                     flush;
  logic                     wb_en;
  logic                     wb_vec_en;
  logic [SEL_BITS-1:0]      wb_idx;
  logic [REG_W*VEC_LEN-1:0] wb_data;
  logic                     out_valid;
  logic [3:0]               op;
  logic [SEL_BITS-1:0]      rd;
  logic [7:0]               imm;
  logic [REG_W-1:0]         a_s;
  logic [REG_W-1:0]         b_s;
  logic [REG_W*VEC_LEN-1:0] a_v;
  logic [REG_W*VEC_LEN-1:0] b_v;
  logic                     mem_write;
  logic                     mem_read;
  logic [1:0]               wb_sel;
  logic                     reg_write_en;
  logic                     vreg_write_en;

  modport master (
    output instr, in_valid, ex_stall, flush, wb_en, wb_vec_en, wb_idx, wb_data,
    input  in_ready, out_valid, op, rd, imm, a_s, b_s, a_v, b_v,
           mem_write, mem_read, wb_sel, reg_write_en, vreg_write_en
  );

  modport slave (
    input  instr, in_valid, ex_stall, flush, wb_en, wb_vec_en, wb_idx, wb_data,
    output in_ready, out_valid, op, rd, imm, a_s, b_s, a_v, b_v,
           mem_write, mem_read, wb_sel, reg_write_en, vreg_write_en
  );
endinterface
`default_nettype wire

// File: rtl/vector_decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vector_decode_stage                                              |
// | ID stage: decode, scalar/vector operand read with bypass,        |
// | load-use bubble, ID/EX register with stall and flush.            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vector_decode_stage #(
  parameter int REG_W     = 8,
  parameter int REG_COUNT = 4,
  parameter int SEL_BITS  = 2,
  parameter int VEC_LEN   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  vector_decode_stage_if.slave bus
);
  localparam int c_vecW = REG_W * VEC_LEN;

  localparam logic [3:0] c_opSalu = 4'h1;
  localparam logic [3:0] c_opLi   = 4'h2;
  localparam logic [3:0] c_opValu = 4'h3;
  localparam logic [3:0] c_opVld  = 4'h4;
  localparam logic [3:0] c_opVst  = 4'h5;

  typedef struct packed {
    logic                valid;
    logic [3:0]          op;
    logic [SEL_BITS-1:0] rd;
    logic [7:0]          imm;
    logic [REG_W-1:0]    aS;
    logic [REG_W-1:0]    bS;
    logic [c_vecW-1:0]   aV;
    logic [c_vecW-1:0]   bV;
    logic                memWrite;
    logic                memRead;
    logic [1:0]          wbSel;
    logic                regWe;
    logic                vregWe;
  } t_idEx;

  logic [REG_W-1:0]    r_sReg [REG_COUNT];
  logic [c_vecW-1:0]   r_vReg [REG_COUNT];
  t_idEx               r_idEx;
  t_idEx               w_next;

  logic [3:0]          w_op;
  logic [3:0]          w_rdField;
  logic [3:0]          w_rs1Field;
  logic [3:0]          w_rs2Field;
  logic [SEL_BITS-1:0] w_rd;
  logic [SEL_BITS-1:0] w_rs1;
  logic [SEL_BITS-1:0] w_rs2;
  logic                w_unusedIdxBits;
  logic                w_useRs1;
  logic                w_useRs2;
  logic                w_hazard;

  assign w_op       = bus.instr[15:12];
  assign w_rdField  = bus.instr[11:8];
  assign w_rs1Field = bus.instr[7:4];
  assign w_rs2Field = bus.instr[3:0];
  assign w_rd       = w_rdField[SEL_BITS-1:0];
  assign w_rs1      = w_rs1Field[SEL_BITS-1:0];
  assign w_rs2      = w_rs2Field[SEL_BITS-1:0];
  // Index bits above SEL_BITS are ignored by design.
  assign w_unusedIdxBits = ^{w_rdField, w_rs1Field, w_rs2Field};

  always_comb begin
    w_next       = '0;
    w_next.valid = 1'b1;
    w_next.op    = w_op;
    w_next.rd    = w_rd;
    w_next.imm   = bus.instr[7:0];
    // Same-cycle write-back forwarding into the operand read.
    w_next.aS    = (bus.wb_en && bus.wb_idx == w_rs1) ? bus.wb_data[REG_W-1:0] : r_sReg[w_rs1];
    w_next.bS    = (bus.wb_en && bus.wb_idx == w_rs2) ? bus.wb_data[REG_W-1:0] : r_sReg[w_rs2];
    w_next.aV    = (bus.wb_vec_en && bus.wb_idx == w_rs1) ? bus.wb_data : r_vReg[w_rs1];
    w_next.bV    = (bus.wb_vec_en && bus.wb_idx == w_rs2) ? bus.wb_data : r_vReg[w_rs2];
    w_useRs1     = 1'b0;
    w_useRs2     = 1'b0;
    case (w_op)
      c_opSalu: begin w_next.regWe = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1; end
      c_opLi:   begin w_next.regWe = 1'b1; w_next.wbSel = 2'b10; end
      c_opValu: begin w_next.vregWe = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1; end
      c_opVld:  begin
        w_next.memRead = 1'b1;
        w_next.wbSel   = 2'b01;
        w_next.vregWe  = 1'b1;
        w_useRs1       = 1'b1;
      end
      c_opVst:  begin w_next.memWrite = 1'b1; w_useRs1 = 1'b1; w_useRs2 = 1'b1; end
      default:  ;
    endcase
  end

  // Load-use: the load result is not forwardable yet, so one bubble covers it.
  assign w_hazard = r_idEx.valid && (r_idEx.op == c_opVld) && bus.in_valid &&
                    ((w_useRs1 && w_rs1 == r_idEx.rd) || (w_useRs2 && w_rs2 == r_idEx.rd));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_sReg[i] <= '0;
        r_vReg[i] <= '0;
      end
    end else begin
      if (bus.wb_en)     r_sReg[bus.wb_idx] <= bus.wb_data[REG_W-1:0];
      if (bus.wb_vec_en) r_vReg[bus.wb_idx] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_idEx <= '0;
    else if (bus.flush)                     r_idEx <= '0;
    else if (bus.ex_stall)                  r_idEx <= r_idEx;
    else if (w_hazard || !bus.in_valid)     r_idEx <= '0;
    else                                    r_idEx <= w_next;
  end

  assign bus.in_ready      = !bus.ex_stall && !w_hazard;
  assign bus.out_valid     = r_idEx.valid;
  assign bus.op            = r_idEx.op;
  assign bus.rd            = r_idEx.rd;
  assign bus.imm           = r_idEx.imm;
  assign bus.a_s           = r_idEx.aS;
  assign bus.b_s           = r_idEx.bS;
  assign bus.a_v           = r_idEx.aV;
  assign bus.b_v           = r_idEx.bV;
  assign bus.mem_write     = r_idEx.memWrite;
  assign bus.mem_read      = r_idEx.memRead;
  assign bus.wb_sel        = r_idEx.wbSel;
  assign bus.reg_write_en  = r_idEx.regWe;
  assign bus.vreg_write_en = r_idEx.vregWe;
endmodule
`default_nettype wire

// File: tb/tb_vector_decode_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vector_decode_stage                                           |
// | Directed and random bench against a behavioural model.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_vector_decode_stage;
  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [7:0]  imm;
    logic [7:0]  aS;
    logic [7:0]  bS;
    logic [31:0] aV;
    logic [31:0] bV;
    logic        mw;
    logic        mr;
    logic [1:0]  wbSel;
    logic        rwe;
    logic        vwe;
  } t_exp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  sRef [4];
  logic [31:0] vRef [4];
  t_exp        m;

  vector_decode_stage_if #(.REG_W(8), .SEL_BITS(2), .VEC_LEN(4)) vif ();

  vector_decode_stage #(.REG_W(8), .REG_COUNT(4), .SEL_BITS(2), .VEC_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] readS(logic [1:0] i);
    return (vif.wb_en && vif.wb_idx == i) ? vif.wb_data[7:0] : sRef[i];
  endfunction

  function automatic logic [31:0] readV(logic [1:0] i);
    return (vif.wb_vec_en && vif.wb_idx == i) ? vif.wb_data : vRef[i];
  endfunction

  function automatic t_exp decode(logic [15:0] ins);
    t_exp e;
    logic [5:0] ctl;
    e = '0;
    e.valid = 1'b1;
    e.op  = ins[15:12];
    e.rd  = ins[9:8];
    e.imm = ins[7:0];
    e.aS  = readS(ins[5:4]);
    e.bS  = readS(ins[1:0]);
    e.aV  = readV(ins[5:4]);
    e.bV  = readV(ins[1:0]);
    case (ins[15:12])
      4'h1:    ctl = 6'b000010;
      4'h2:    ctl = 6'b001010;
      4'h3:    ctl = 6'b000001;
      4'h4:    ctl = 6'b010101;
      4'h5:    ctl = 6'b100000;
      default: ctl = 6'b000000;
    endcase
    {e.mw, e.mr, e.wbSel, e.rwe, e.vwe} = ctl;
    return e;
  endfunction

  function automatic logic hazard();
    logic [3:0] op;
    logic       readsA;
    logic       readsB;
    op     = vif.instr[15:12];
    readsA = (op == 4'h1) || (op == 4'h3) || (op == 4'h4) || (op == 4'h5);
    readsB = (op == 4'h1) || (op == 4'h3) || (op == 4'h5);
    return m.valid && (m.op == 4'h4) && vif.in_valid &&
           ((readsA && vif.instr[5:4] == m.rd) || (readsB && vif.instr[1:0] == m.rd));
  endfunction

  function automatic t_exp observe();
    t_exp o;
    o.valid = vif.out_valid;     o.op = vif.op;       o.rd = vif.rd;
    o.imm = vif.imm;             o.aS = vif.a_s;      o.bS = vif.b_s;
    o.aV = vif.a_v;              o.bV = vif.b_v;      o.mw = vif.mem_write;
    o.mr = vif.mem_read;         o.wbSel = vif.wb_sel;
    o.rwe = vif.reg_write_en;    o.vwe = vif.vreg_write_en;
    return o;
  endfunction

  // Bubble payload is don't-care apart from valid and the controls.
  function automatic t_exp vis(t_exp e);
    if (!e.valid) begin
      e.op = '0; e.rd = '0; e.imm = '0; e.aS = '0; e.bS = '0; e.aV = '0; e.bV = '0;
    end
    return e;
  endfunction

  task automatic clearModel();
    m = '0;
    for (int i = 0; i < 4; i++) begin sRef[i] = '0; vRef[i] = '0; end
  endtask

  task automatic idle();
    vif.instr = '0; vif.in_valid = 1'b0; vif.ex_stall = 1'b0; vif.flush = 1'b0;
    vif.wb_en = 1'b0; vif.wb_vec_en = 1'b0; vif.wb_idx = '0; vif.wb_data = '0;
  endtask

  task automatic tick();
    t_exp nxt;
    if (vif.flush)                          nxt = '0;
    else if (vif.ex_stall)                  nxt = m;
    else if (hazard() || !vif.in_valid)     nxt = '0;
    else                                    nxt = decode(vif.instr);
    if (vif.wb_en)     sRef[vif.wb_idx] = vif.wb_data[7:0];
    if (vif.wb_vec_en) vRef[vif.wb_idx] = vif.wb_data;
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic test_reset();
    t_exp z;
    z = '0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (observe() !== z) begin bad++; $display("FAIL reset_state: got %h want %h", observe(), z); end
    reset = 1'b0;
    clearModel();
    #1;
    total++;
    if (vif.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", vif.in_ready); end
  endtask

  task automatic test_li();
    idle();
    vif.instr = 16'h2A5C; vif.in_valid = 1'b1;
    tick();
    total++;
    if ({vif.out_valid, vif.op, vif.rd, vif.imm, vif.wb_sel, vif.reg_write_en,
         vif.vreg_write_en, vif.mem_read, vif.mem_write} !==
        {1'b1, 4'h2, 2'h2, 8'h5C, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0})
    begin bad++; $display("FAIL li_fields: got op=%h rd=%h imm=%h wbsel=%b", vif.op, vif.rd, vif.imm, vif.wb_sel); end
    total++;
    if (vis(observe()) !== vis(m)) begin bad++; $display("FAIL li_model: got %h want %h", observe(), m); end
  endtask

  task automatic test_bypass();
    idle();
    vif.wb_vec_en = 1'b1; vif.wb_idx = 2'd1; vif.wb_data = 32'h04030201;
    vif.instr = 16'h3012; vif.in_valid = 1'b1;
    tick();
    total++;
    if (vif.a_v !== 32'h04030201) begin bad++; $display("FAIL bypass_av: got %h want 04030201", vif.a_v); end
    vif.wb_vec_en = 1'b0; vif.wb_data = '0;
    tick();
    total++;
    if (vif.a_v !== 32'h04030201) begin bad++; $display("FAIL stored_av: got %h want 04030201", vif.a_v); end
    total++;
    if (vis(observe()) !== vis(m)) begin bad++; $display("FAIL bypass_model: got %h want %h", observe(), m); end
  endtask

  task automatic test_hazard();
    idle();
    vif.instr = 16'h4310; vif.in_valid = 1'b1;
    tick();
    vif.instr = 16'h3032;
    #1;
    total++;
    if (vif.in_ready !== 1'b0) begin bad++; $display("FAIL hazard_ready: got %b want 0", vif.in_ready); end
    tick();
    total++;
    if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL hazard_bubble: got %b want 0", vif.out_valid); end
    total++;
    if (vif.in_ready !== 1'b1) begin bad++; $display("FAIL hazard_release: got %b want 1", vif.in_ready); end
    tick();
    total++;
    if ({vif.out_valid, vif.op, vif.vreg_write_en} !== {1'b1, 4'h3, 1'b1})
    begin bad++; $display("FAIL hazard_accept: got v=%b op=%h want v=1 op=3", vif.out_valid, vif.op); end
  endtask

  task automatic test_stall();
    t_exp held;
    idle();
    vif.instr = 16'h1123; vif.in_valid = 1'b1;
    tick();
    held = m;
    vif.ex_stall = 1'b1; vif.instr = 16'h2377;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (vif.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b want 0", vif.in_ready); end
      tick();
      total++;
      if (observe() !== held || vif.op !== 4'h1)
      begin bad++; $display("FAIL stall_hold: got %h want %h", observe(), held); end
    end
    vif.ex_stall = 1'b0;
    tick();
    total++;
    if ({vif.out_valid, vif.op, vif.rd, vif.imm} !== {1'b1, 4'h2, 2'h3, 8'h77})
    begin bad++; $display("FAIL stall_next: got op=%h rd=%h imm=%h want op=2 rd=3 imm=77", vif.op, vif.rd, vif.imm); end
  endtask

  task automatic test_flush();
    idle();
    vif.flush = 1'b1; vif.ex_stall = 1'b1; vif.in_valid = 1'b1; vif.instr = 16'h2155;
    tick();
    total++;
    if ({vif.out_valid, vif.reg_write_en, vif.wb_sel} !== 4'b0000)
    begin bad++; $display("FAIL flush: got v=%b rwe=%b want 0", vif.out_valid, vif.reg_write_en); end
  endtask

  task automatic test_opf();
    idle();
    vif.instr = 16'hF123; vif.in_valid = 1'b1;
    tick();
    total++;
    if ({vif.out_valid, vif.op, vif.mem_write, vif.mem_read, vif.wb_sel, vif.reg_write_en, vif.vreg_write_en} !==
        {1'b1, 4'hF, 6'b000000})
    begin bad++; $display("FAIL opf: got v=%b op=%h mw=%b mr=%b", vif.out_valid, vif.op, vif.mem_write, vif.mem_read); end
  endtask

  task automatic test_reset_mid_hazard();
    idle();
    vif.wb_en = 1'b1; vif.wb_vec_en = 1'b1; vif.wb_idx = 2'd3; vif.wb_data = 32'hDEADBEEF;
    vif.instr = 16'h4310; vif.in_valid = 1'b1;
    tick();
    vif.wb_en = 1'b0; vif.wb_vec_en = 1'b0;
    vif.instr = 16'h3032;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (vif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_async: got %b want 0", vif.out_valid); end
    clearModel();
    #1;
    reset = 1'b0;
    vif.instr = 16'h1333;
    tick();
    total++;
    if ({vif.out_valid, vif.a_s, vif.b_s} !== {1'b1, 16'h0000})
    begin bad++; $display("FAIL reset_sreg: got a=%h b=%h want 0", vif.a_s, vif.b_s); end
    vif.instr = 16'h3033;
    tick();
    total++;
    if ({vif.out_valid, vif.a_v} !== {1'b1, 32'h0})
    begin bad++; $display("FAIL reset_vreg: got %h want 0", vif.a_v); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      vif.instr     = {(($urandom % 4) == 0) ? 4'h4 : 4'($urandom_range(0, 15)), 12'($urandom)};
      vif.in_valid  = ($urandom % 10) < 7;
      vif.ex_stall  = ($urandom % 10) < 2;
      vif.flush     = ($urandom % 20) == 0;
      vif.wb_en     = ($urandom % 2) == 0;
      vif.wb_vec_en = ($urandom % 2) == 0;
      vif.wb_idx    = 2'($urandom);
      vif.wb_data   = $urandom;
      #1;
      total++;
      if (vif.in_ready !== (!vif.ex_stall && !hazard()))
      begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, vif.in_ready, !vif.ex_stall && !hazard()); end
      tick();
      total++;
      if (vis(observe()) !== vis(m))
      begin bad++; $display("FAIL rand_idex[%0d]: got %h want %h", i, observe(), m); end
    end
  endtask

  initial begin
    idle();
    clearModel();
    test_reset();
    test_li();
    test_bypass();
    test_hazard();
    test_stall();
    test_flush();
    test_opf();
    test_reset_mid_hazard();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vector_decode_stage.md
Name: vector_decode_stage

Overview:
- Parametrised ID stage for the vector ASIP. It sits between fetch and execute.
- Accepts a 16-bit instruction with a valid/ready handshake, then decodes it into control signals.
- Reads operands from internal scalar and vector register files, with write-back bypass.
- Detects load-use hazards and inserts bubbles.
- Registers everything into an ID/EX pipeline register that supports stall and flush.

Parameters:
REG_W, 8, width of scalar register and of each vector lane
REG_COUNT, 4, registers per file (scalar and vector)
SEL_BITS, 2, index width; equals log2(REG_COUNT), legal 1..4
VEC_LEN, 4, lanes per vector register

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
instr  in  16  instruction from fetch
in_valid  in  1  instr valid
in_ready  out  1  stage can accept instr this cycle
ex_stall  in  1  execute cannot accept; hold ID/EX register
flush  in  1  discard the ID/EX contents and the incoming instr
wb_en  in  1  scalar write-back enable
wb_vec_en  in  1  vector write-back enable
wb_idx  in  SEL_BITS  write-back register index
wb_data  in  REG_W*VEC_LEN  write-back data (scalar uses bits [REG_W-1:0])
out_valid  out  1  ID/EX register holds a real instruction
op  out  4  opcode
rd  out  SEL_BITS  destination index
imm  out  8  immediate, zero-extended by execute
a_s, b_s  out  REG_W  scalar operands rs1, rs2
a_v, b_v  out  REG_W*VEC_LEN  vector operands vs1, vs2
mem_write  out  1  store
mem_read  out  1  load
wb_sel  out  2  result source: 00 ALU, 01 memory, 10 immediate
reg_write_en  out  1  scalar write-back
vreg_write_en  out  1  vector write-back

Behaviour:
- Encoding:
  - op=instr[15:12], rd=instr[11:8], rs1=instr[7:4], rs2=instr[3:0], imm=instr[7:0].
  - Each index uses only its low SEL_BITS bits.
- Decode table (mem_write, mem_read, wb_sel, reg_write_en, vreg_write_en):
  - 0x0 NOP: 0,0,00,0,0
  - 0x1 SALU: 0,0,00,1,0
  - 0x2 LI: 0,0,10,1,0
  - 0x3 VALU: 0,0,00,0,1
  - 0x4 VLD (address in rs1): 0,1,01,0,1
  - 0x5 VST (vs2 to address rs1): 1,0,00,0,0
  - 0x6..0xF: treated as NOP, and out_valid is still set.
- Register files are read combinationally. Writes occur on the rising clock edge.
- Bypass: if wb_en (or wb_vec_en) is set and wb_idx matches a read index in the same cycle, the operand takes wb_data, not the stored value.
- Hazard:
  - Condition: out_valid=1, the ID/EX instruction is VLD, and the incoming valid instr reads rd_ex. Sources count only if the op uses them:
    - SALU: rs1, rs2
    - VALU: vs1, vs2
    - VLD: rs1
    - VST: rs1, vs2
  - Response: in_ready=0 and a bubble is loaded (out_valid=0, all controls 0). The stall lasts exactly 1 cycle.
- in_ready = !ex_stall && !hazard.
- Per-edge priority:
  1. reset
  2. flush: out_valid<=0, all controls 0, input dropped
  3. ex_stall: ID/EX held unchanged
  4. hazard: bubble
  5. in_valid: load decoded instr
  6. otherwise: bubble
- Register-file writes ignore stall, flush and hazard. They are blocked only by reset.
- Latency: 1 cycle from an accepted instr to out_valid.
- Reset (async, any time, including mid-stall):
  - out_valid=0 and all ID/EX fields are 0.
  - Every scalar and vector register is 0.
  - in_ready is 1 once reset is released, while ex_stall=0.

Test Plan:
- Reset, then in_valid=1 with instr 0x2A5C (LI r2,0x5C, SEL_BITS=2) -> next cycle out_valid=1, op=2, rd=2, imm=0x5C, wb_sel=10, reg_write_en=1, all other controls 0.
- Write-back wb_vec_en=1, wb_idx=1, wb_data=0x04030201; same cycle instr 0x3012 (VALU v0,v1,v2) -> a_v=0x04030201 (bypass); the next read of v1 gives 0x04030201.
- Accept VLD 0x4310 (rd=3). Next instr 0x3032 reads v3 -> in_ready=0 for 1 cycle and a bubble is output (out_valid=0). The VALU is accepted the following cycle.
- Hold ex_stall=1 for 3 cycles while a SALU sits in ID/EX -> outputs unchanged and in_ready=0. Release -> the next instr loads.
- flush=1 and ex_stall=1 together with in_valid=1 -> out_valid=0 next cycle; flush wins.
- Opcode 0xF -> out_valid=1, all write and memory controls 0. Assert reset mid-hazard -> out_valid=0 immediately and registers read 0.
